// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared widths, requester encoding and writeback payload for the register-file
// writeback scoreboard.
package regfile_wb_scoreboard_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = AW + 1;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // A register is a hazard when it is not x0 and still has a write in flight.
  function automatic logic reg_hazard(input logic [AW-1:0] r, input logic [NREG-1:0] busy);
    return (r != '0) && busy[r];
  endfunction

endpackage

// File: rtl/regfile_wb_scoreboard_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, winner remembered at the edge.
import regfile_wb_scoreboard_pkg::*;

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e rr_last;

  // On a conflict the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_last == REQ_MEM) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= REQ_MEM;
    end else if (gnt[REQ_ALU]) begin
      rr_last <= REQ_ALU;
    end else if (gnt[REQ_MEM]) begin
      rr_last <= REQ_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Shares the register-file write port between ALU and load writeback and tracks
// per-register busy bits so issue stalls on RAW/WAW hazards.
import regfile_wb_scoreboard_pkg::*;

module regfile_wb_scoreboard (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wr,
  output logic            issue_stall,
  input  logic            alu_req,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_gnt,
  input  logic            mem_req,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_gnt,
  output logic            regWrite,
  output logic [AW-1:0]   writeRegister,
  output logic [XLEN-1:0] writeData,
  output logic [CW-1:0]   pending_cnt,
  output logic            err
);

  logic [NREG-1:0] busy;
  logic [1:0]      gnt;
  logic            any_gnt;
  wb_req_t         sel;
  logic            set_en;
  logic            clr_en;
  logic            err_set;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_req, alu_req}),
    .gnt (gnt)
  );

  assign alu_gnt = gnt[REQ_ALU];
  assign mem_gnt = gnt[REQ_MEM];
  assign any_gnt = |gnt;

  always_comb begin
    issue_stall = 1'b0;
    set_en      = 1'b0;
    sel         = '0;
    err_set     = 1'b0;
    set_mask    = '0;
    clr_mask    = '0;
    if (!rst) begin
      issue_stall = issue_valid && (reg_hazard(issue_rs1, busy) || reg_hazard(issue_rs2, busy) ||
                                    (issue_wr && reg_hazard(issue_rd, busy)));
    end
    set_en = issue_valid && !issue_stall && issue_wr && (issue_rd != '0) && !rst;
    sel    = gnt[REQ_MEM] ? wb_req_t'{rd: mem_rd, data: mem_data}
                          : wb_req_t'{rd: alu_rd, data: alu_data};
    // A write to a register nobody issued is still performed, but flagged.
    err_set = any_gnt && (sel.rd != '0) && !busy[sel.rd];
    if (set_en) set_mask = NREG'(1) << issue_rd;
    if (clr_en) clr_mask = NREG'(1) << writeRegister;
  end

  // Clear coincides with the register-file commit, so no bypass is needed.
  assign clr_en = regWrite && busy[writeRegister];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      pending_cnt   <= '0;
      err           <= 1'b0;
    end else begin
      busy     <= (busy & ~clr_mask) | set_mask;
      regWrite <= any_gnt && (sel.rd != '0);
      if (any_gnt) begin
        writeRegister <= sel.rd;
        writeData     <= sel.data;
      end
      case ({set_en, clr_en})
        2'b10:   pending_cnt <= pending_cnt + CW'(1);
        2'b01:   pending_cnt <= pending_cnt - CW'(1);
        default: pending_cnt <= pending_cnt;
      endcase
      if (err_set) err <= 1'b1;
    end
  end

endmodule
